// File: rtl/dmem_if.sv
// Datapath-to-data-memory bus: load/store request from the memory stage, load data and stall back.
interface dmem_if;
    logic [31:0] a;
    logic [31:0] wd;
    logic        we;
    logic        re;
    logic [31:0] rd;
    logic        stall;
    logic        err;

    modport master (output a, wd, we, re, input rd, stall, err);
    modport slave  (input a, wd, we, re, output rd, stall, err);
endinterface

// File: rtl/dmem_ctrl.sv
// Data memory controller: word RAM with multi-cycle reads, pipeline stall and sticky error flag.
// Optional DMEM_MMIO_EN maps an LED register and the cycle counter at 0xFFFFFF00/0xFFFFFF04.
module dmem_ctrl #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
`ifdef DMEM_MMIO_EN
    localparam logic [31:0] LED_ADDR = 32'hFFFF_FF00;
    localparam logic [31:0] CYC_ADDR = 32'hFFFF_FF04;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        rd_q, rd_d;
    logic               err_q, err_d;
    logic [31:0]        cyc_q;
    logic [31:0]        mem_q [DEPTH];

    logic               stall_c;
    logic               mem_we_c;
    logic               led_we_c;
    logic               aligned_c;
    logic [31:0]        rdata_c;

`ifdef DMEM_MMIO_EN
    logic [31:0]        led_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         led_q <= 32'd0;
        else if (led_we_c) led_q <= bus.wd;
    end

    always_comb begin
        if (addr_q == LED_ADDR)      rdata_c = led_q;
        else if (addr_q == CYC_ADDR) rdata_c = cyc_q;
        else                         rdata_c = mem_q[addr_q[IDX_W+1:2]];
    end
`else
    logic unused_bits;
    assign unused_bits = ^{cyc_q, led_we_c, addr_q[31:IDX_W+2], addr_q[1:0], bus.a[31:IDX_W+2]};
    assign rdata_c     = mem_q[addr_q[IDX_W+1:2]];
`endif

    assign aligned_c = (bus.a[1:0] == 2'b00);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        rd_d     = rd_q;
        err_d    = err_q;
        stall_c  = 1'b0;
        mem_we_c = 1'b0;
        led_we_c = 1'b0;
        case (state_q)
            IDLE: begin
                if ((bus.we || bus.re) && !aligned_c) begin
                    err_d = 1'b1;
                end else if (bus.we) begin
                    // a combined store+load performs the store only and flags the conflict
                    err_d = bus.re ? 1'b1 : err_q;
`ifdef DMEM_MMIO_EN
                    if (bus.a == LED_ADDR)      led_we_c = !reset;
                    else if (bus.a != CYC_ADDR) mem_we_c = !reset;
`else
                    mem_we_c = !reset;
`endif
                end else if (bus.re) begin
                    stall_c = 1'b1;
                    addr_d  = bus.a;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                if (cnt_q == '0) begin
                    rd_d    = rdata_c;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= 32'd0;
            rd_q    <= 32'd0;
            err_q   <= 1'b0;
            cyc_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            cyc_q   <= cyc_q + 32'd1;
        end
    end

    // RAM has no reset; contents survive reset and aborted reads
    always_ff @(posedge clk) begin
        if (mem_we_c) mem_q[bus.a[IDX_W+1:2]] <= bus.wd;
    end

    assign bus.stall = stall_c & ~reset;
    assign bus.rd    = rd_q;
    assign bus.err   = err_q;
endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DEPTH, default 64: RAM size in 32-bit words, power of two, at least 4.
REQ-002 Parameter LATENCY, default 2: read wait cycles, at least 1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 a  input  32  byte address from the datapath memory stage (aluoutm).
REQ-006 wd  input  32  store data (writedatam).
REQ-007 we  input  1  store request (memwritem).
REQ-008 re  input  1  load request (memtoregm).
REQ-009 rd  output  32  load data (rdm).
REQ-010 stall  output  1  to hazard unit; freezes the pipeline while high.
REQ-011 err  output  1  sticky access-error flag.

Function
REQ-012 The RAM index SHALL be a[log2(DEPTH)+1:2], so addresses wrap modulo DEPTH words; upper bits are ignored.
REQ-013 An access with a[1:0] != 0 SHALL be ignored (no write, no FSM change, stall=0) and SHALL set err.
REQ-014 The FSM SHALL have states IDLE, WAIT and DONE.
REQ-015 Write in IDLE: with we=1 and an aligned address, mem[idx] SHALL take wd at the edge, with stall=0 and the FSM staying in IDLE.
REQ-016 Write in WAIT or DONE: we=1 SHALL be ignored.
REQ-017 Read start: in IDLE with re=1, we=0 and an aligned address, stall SHALL be 1 combinationally.
REQ-018 At that edge, the controller SHALL latch the address, load a counter with LATENCY-1 and enter WAIT.
REQ-019 In WAIT, stall SHALL be 1 and the counter SHALL decrement each edge.
REQ-020 In WAIT with counter==0, the controller SHALL capture rd=mem[latched idx] and enter DONE.
REQ-021 In DONE, stall SHALL be 0 and rd SHALL hold its value; the next edge SHALL return the FSM to IDLE.
REQ-022 Read timing: stall SHALL be high for exactly LATENCY+1 consecutive cycles, with data valid in the following cycle.
REQ-023 Changes on a, re or we during WAIT SHALL NOT affect the read in progress.
REQ-024 Simultaneous we=1 and re=1 in IDLE SHALL perform the write only, set err, and leave stall=0.
REQ-025 rd SHALL change only in WAIT-to-DONE transitions and on reset.
REQ-026 A 32-bit free-running cycle counter SHALL increment every edge and wrap from 0xFFFFFFFF to 0.

Reset
REQ-027 Asserting reset SHALL force, immediately: FSM=IDLE, stall=0, rd=0, err=0, wait counter=0, cycle counter=0, and LED register=0.
REQ-028 Reset asserted mid-read SHALL abort the read and leave RAM unchanged.
REQ-029 RAM contents SHALL NOT be reset.

Configuration
REQ-030 Macro DMEM_MMIO_EN SHALL control the MMIO region.
REQ-031 With DMEM_MMIO_EN defined, writes to 0xFFFFFF00 SHALL store wd in the LED register instead of RAM.
REQ-032 With DMEM_MMIO_EN defined, reads of 0xFFFFFF00 SHALL return the LED register and reads of 0xFFFFFF04 SHALL return the cycle counter.
REQ-033 With DMEM_MMIO_EN defined, MMIO reads SHALL use the same FSM and latency as RAM reads, and writes to 0xFFFFFF04 SHALL be ignored without setting err.
REQ-034 Without DMEM_MMIO_EN, the LED register SHALL be absent and all addresses SHALL map to RAM per REQ-012.

Verification
REQ-035 Store then load: store a=0x10, wd=0xDEADBEEF, then load a=0x10 with LATENCY=2 -> stall high 3 cycles, then rd=0xDEADBEEF with stall=0.
REQ-036 Wrap-around: with DEPTH=64, store a=0x100, wd=0x12345678, then load a=0x0 -> rd=0x12345678.
REQ-037 Misaligned: store a=0x13 -> RAM unchanged, err=1, stall=0; err stays 1 until reset.
REQ-038 Latched address and priority: change a during WAIT -> rd comes from the original address; we=1 and re=1 together -> write occurs, err=1.
REQ-039 Reset mid-read: assert reset during WAIT -> stall=0 and rd=0 immediately; the prior RAM value is still readable afterwards.
REQ-040 MMIO (DMEM_MMIO_EN): store 0xA5 to 0xFFFFFF00, then load 0xFFFFFF00 -> rd=0xA5; load 0xFFFFFF04 twice -> second value exceeds the first by the cycle gap.
